pattern_tx: RTL and testbench

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_pkg.sv | 14 +
 rtl/pattern_tx.sv | 105 ++++++++++
 tb/tb_pattern_tx.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern transmitter: FSM state encodings and
// default pattern geometry.
package pattern_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int           DEFAULT_W   = 6;
    localparam logic [5:0]   DEFAULT_PAT = 6'b110110;

endpackage

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched W-bit pattern out MSB first,
// repeated rep_i times back to back, with a valid/ready handshake and abort.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [W-1:0]     pat_i,
    input  logic [CNT_W-1:0] rep_i,
    input  logic             abort_i,
    input  logic             ready_i,
    output logic             data_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BIT_W = (W > 1) ? $clog2(W) : 1;

    state_t             state_q, state_n;
    logic [W-1:0]       shift_q, shift_n;
    logic [W-1:0]       pat_q,   pat_n;
    logic [CNT_W-1:0]   rep_q,   rep_n;
    logic [BIT_W-1:0]   bit_q,   bit_n;

    // Outputs are registered from the next-state values so the first bit
    // appears exactly one cycle after start is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            data_o  <= 1'b0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            pat_q   <= pat_n;
            rep_q   <= rep_n;
            bit_q   <= bit_n;
            data_o  <= (state_n == S_SEND) ? shift_n[W-1] : 1'b0;
            valid_o <= (state_n == S_SEND);
            busy_o  <= (state_n != S_IDLE);
            done_o  <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        pat_n   = pat_q;
        rep_n   = rep_q;
        bit_n   = bit_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (rep_i != '0) begin
                        pat_n   = pat_i;
                        shift_n = pat_i;
                        rep_n   = rep_i;
                        bit_n   = '0;
                        state_n = S_SEND;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_SEND: begin
                // Abort takes priority over any handshake on the same cycle.
                if (abort_i) begin
                    state_n = S_IDLE;
                end else if (valid_o && ready_i) begin
                    if (bit_q == BIT_W'(W - 1)) begin
                        if (rep_q > CNT_W'(1)) begin
                            shift_n = pat_q;
                            rep_n   = rep_q - 1'b1;
                            bit_n   = '0;
                        end else begin
                            rep_n   = '0;
                            state_n = S_DONE;
                        end
                    end else begin
                        shift_n = {shift_q[W-2:0], 1'b0};
                        bit_n   = bit_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: expected bits are queued when a
// transfer starts and popped on every observed handshake.
module tb_pattern_tx;
    import pattern_pkg::*;

    localparam int W     = 6;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [W-1:0]     pat_i;
    logic [CNT_W-1:0] rep_i;
    logic             abort_i;
    logic             ready_i;
    logic             data_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;

    int   checks = 0;
    int   passes = 0;
    logic exp_q[$];

    pattern_tx #(.W(W), .CNT_W(CNT_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .pat_i   (pat_i),
        .rep_i   (rep_i),
        .abort_i (abort_i),
        .ready_i (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic push_frame(input logic [W-1:0] pat, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = W - 1; i >= 0; i--)
                exp_q.push_back(pat[i]);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b1;
        pat_i = '0; rep_i = '0;
        @(negedge clk_i);
        checks++; if ({data_o, valid_o, busy_o, done_o} !== 4'b0000)
            $display("[TB] FAIL reset_outputs: got %b want 0000", {data_o, valid_o, busy_o, done_o});
        else passes++;
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({valid_o, busy_o, done_o} !== 3'b000)
            $display("[TB] FAIL idle_after_reset: got %b want 000", {valid_o, busy_o, done_o});
        else passes++;
    endtask

    task automatic test_single();
        logic e;
        exp_q.delete();
        push_frame(DEFAULT_PAT, 1);
        pat_i = DEFAULT_PAT; rep_i = 4'd1; ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            checks++; if (valid_o !== (cyc <= 6))
                $display("[TB] FAIL single_valid c%0d: got %b want %b", cyc, valid_o, (cyc <= 6));
            else passes++;
            checks++; if (done_o !== (cyc == 7))
                $display("[TB] FAIL single_done c%0d: got %b want %b", cyc, done_o, (cyc == 7));
            else passes++;
            checks++; if (busy_o !== (cyc <= 7))
                $display("[TB] FAIL single_busy c%0d: got %b want %b", cyc, busy_o, (cyc <= 7));
            else passes++;
            if (valid_o && ready_i && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (data_o !== e)
                    $display("[TB] FAIL single_data c%0d: got %b want %b", cyc, data_o, e);
                else passes++;
            end
            @(negedge clk_i);
        end
        checks++; if (exp_q.size() != 0)
            $display("[TB] FAIL single_left: got %0d bits unsent want 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_stall();
        logic e;
        int   accepts = 0;
        exp_q.delete();
        push_frame(DEFAULT_PAT, 1);
        pat_i = DEFAULT_PAT; rep_i = 4'd1; ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            ready_i = !(cyc >= 2 && cyc <= 4);
            checks++; if (valid_o !== (cyc <= 9))
                $display("[TB] FAIL stall_valid c%0d: got %b want %b", cyc, valid_o, (cyc <= 9));
            else passes++;
            checks++; if (done_o !== (cyc == 10))
                $display("[TB] FAIL stall_done c%0d: got %b want %b", cyc, done_o, (cyc == 10));
            else passes++;
            if (cyc >= 2 && cyc <= 4) begin
                checks++; if (data_o !== 1'b1)
                    $display("[TB] FAIL stall_hold c%0d: got %b want 1", cyc, data_o);
                else passes++;
            end
            if (valid_o && ready_i) begin
                accepts++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++; if (data_o !== e)
                        $display("[TB] FAIL stall_data c%0d: got %b want %b", cyc, data_o, e);
                    else passes++;
                end
            end
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        checks++; if (accepts != 6)
            $display("[TB] FAIL stall_accepts: got %0d want 6", accepts);
        else passes++;
    endtask

    task automatic test_repeat();
        logic       e;
        logic [5:0] hist = '0;
        int         fill = 0, pd = 0, accepts = 0, done_cyc = -1;
        exp_q.delete();
        push_frame(DEFAULT_PAT, 3);
        pat_i = DEFAULT_PAT; rep_i = 4'd3; ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            // Late start and input changes must not disturb the transfer.
            if (cyc == 4) begin start_i = 1'b1; pat_i = 6'b000001; rep_i = 4'd15; end
            if (cyc == 5) begin start_i = 1'b0; pat_i = DEFAULT_PAT; rep_i = 4'd0; end
            checks++; if (valid_o !== (cyc <= 18))
                $display("[TB] FAIL repeat_valid c%0d: got %b want %b", cyc, valid_o, (cyc <= 18));
            else passes++;
            if (done_o && done_cyc < 0) done_cyc = cyc;
            if (valid_o && ready_i) begin
                accepts++;
                hist = {hist[4:0], data_o};
                fill++;
                if (fill >= 6 && hist == 6'b110110) begin pd++; fill = 0; end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++; if (data_o !== e)
                        $display("[TB] FAIL repeat_data c%0d: got %b want %b", cyc, data_o, e);
                    else passes++;
                end
            end
            @(negedge clk_i);
        end
        checks++; if (accepts != 18)
            $display("[TB] FAIL repeat_accepts: got %0d want 18", accepts);
        else passes++;
        checks++; if (pd != 3)
            $display("[TB] FAIL repeat_detect: got %0d want 3", pd);
        else passes++;
        checks++; if (done_cyc != 19)
            $display("[TB] FAIL repeat_done_cycle: got %0d want 19", done_cyc);
        else passes++;
    endtask

    task automatic test_zero_rep();
        pat_i = DEFAULT_PAT; rep_i = 4'd0; ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            checks++; if (valid_o !== 1'b0)
                $display("[TB] FAIL zero_valid c%0d: got %b want 0", cyc, valid_o);
            else passes++;
            checks++; if (done_o !== (cyc == 1))
                $display("[TB] FAIL zero_done c%0d: got %b want %b", cyc, done_o, (cyc == 1));
            else passes++;
            checks++; if (busy_o !== (cyc == 1))
                $display("[TB] FAIL zero_busy c%0d: got %b want %b", cyc, busy_o, (cyc == 1));
            else passes++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_abort();
        logic e;
        exp_q.delete();
        push_frame(DEFAULT_PAT, 1);
        pat_i = DEFAULT_PAT; rep_i = 4'd1; ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            abort_i = (cyc == 6);
            checks++; if (valid_o !== (cyc <= 6))
                $display("[TB] FAIL abort_valid c%0d: got %b want %b", cyc, valid_o, (cyc <= 6));
            else passes++;
            checks++; if (done_o !== 1'b0)
                $display("[TB] FAIL abort_done c%0d: got %b want 0", cyc, done_o);
            else passes++;
            checks++; if (busy_o !== (cyc <= 6))
                $display("[TB] FAIL abort_busy c%0d: got %b want %b", cyc, busy_o, (cyc <= 6));
            else passes++;
            if (valid_o && ready_i && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (data_o !== e)
                    $display("[TB] FAIL abort_data c%0d: got %b want %b", cyc, data_o, e);
                else passes++;
            end
            @(negedge clk_i);
        end
        abort_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic e;
        pat_i = DEFAULT_PAT; rep_i = 4'd1; ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checks++; if ({data_o, valid_o, busy_o, done_o} !== 4'b0000)
            $display("[TB] FAIL async_reset: got %b want 0000", {data_o, valid_o, busy_o, done_o});
        else passes++;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({valid_o, done_o} !== 2'b00)
            $display("[TB] FAIL reset_no_done: got %b want 00", {valid_o, done_o});
        else passes++;
        exp_q.delete();
        push_frame(DEFAULT_PAT, 1);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            checks++; if (done_o !== (cyc == 7))
                $display("[TB] FAIL rerun_done c%0d: got %b want %b", cyc, done_o, (cyc == 7));
            else passes++;
            if (valid_o && ready_i && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if (data_o !== e)
                    $display("[TB] FAIL rerun_data c%0d: got %b want %b", cyc, data_o, e);
                else passes++;
            end
            @(negedge clk_i);
        end
        checks++; if (exp_q.size() != 0)
            $display("[TB] FAIL rerun_left: got %0d bits unsent want 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_repeat();
        test_zero_rep();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
